pipe_hazard_ctrl: RTL and testbench

//  Sequences the 5-stage RV64 pipeline registers (IF/ID, ID/EX, EX/MEM) and the PC.

---
 rtl/pipe_hazard_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage RV64 core.
// Drives the PC and pipeline-register enables. It stalls on load-use hazards,
// flushes on taken branches, and freezes while data memory is busy. A memory
// access that never completes halts the pipeline. It also keeps saturating
// stall and flush counters.
module pipe_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       state,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // flush_left never exceeds FLUSH_CYCLES-1; wait_cnt must reach MEM_TIMEOUT.
  localparam int unsigned FlW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned WcW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StFlush   = 2'd2,
    StHalt    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WcW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [FlW-1:0]   flush_left_q, flush_left_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic mem_stall;

  // Hazard detection; x0 is never a real dependency.
  always_comb begin
    load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
    mem_stall = mem_req && !mem_ready;
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StRun;
      wait_cnt_q   <= '0;
      flush_left_q <= '0;
      mem_err_q    <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      flush_left_q <= flush_left_d;
      mem_err_q    <= mem_err_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  // Next-state logic plus the saturating performance counters.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    flush_left_d = flush_left_q;
    mem_err_d    = mem_err_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;

    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          state_d    = StMemWait;
          wait_cnt_d = WcW'(1);
        end else if (ex_branch_taken && (FLUSH_CYCLES > 1)) begin
          state_d      = StFlush;
          flush_left_d = FlW'(FLUSH_CYCLES - 1);
        end
      end
      StMemWait: begin
        if (mem_ready) begin
          wait_cnt_d = '0;
          // A branch held in the frozen EX stage resolves now.
          if (ex_branch_taken && (FLUSH_CYCLES > 1)) begin
            state_d      = StFlush;
            flush_left_d = FlW'(FLUSH_CYCLES - 1);
          end else begin
            state_d = StRun;
          end
        end else if (wait_cnt_q == WcW'(MEM_TIMEOUT)) begin
          state_d   = StHalt;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WcW'(1);
        end
      end
      StFlush: begin
        if (!mem_stall) begin
          flush_left_d = flush_left_q - FlW'(1);
          if (flush_left_q == FlW'(1)) begin
            state_d = StRun;
          end
        end
      end
      StHalt: begin
      end
    endcase

    if (!pc_en && (state_q != StHalt) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (if_id_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  logic do_freeze;
  logic do_decode;
  logic do_flush;

  // Select the control action for this cycle: freeze, flush, or normal decode.
  always_comb begin
    do_freeze = 1'b0;
    do_decode = 1'b0;
    do_flush  = 1'b0;
    unique case (state_q)
      StRun:     begin do_freeze = mem_stall;  do_decode = !mem_stall; end
      StMemWait: begin do_freeze = !mem_ready; do_decode = mem_ready;  end
      StFlush:   begin do_freeze = mem_stall;  do_flush  = !mem_stall; end
      StHalt:    begin do_freeze = 1'b1; end
    endcase
  end

  // Control outputs; reset forces all enables low and a bubble into ID/EX.
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b1;
    if (!reset) begin
      if (do_freeze) begin
        id_ex_bubble = 1'b0;
      end else if (do_flush || (do_decode && ex_branch_taken)) begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        if_id_flush  = 1'b1;
      end else if (load_use) begin
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
      end else begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        id_ex_bubble = 1'b0;
      end
    end
  end

  assign state     = state_q;
  assign halted    = (state_q == StHalt);
  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios then random stimulus,
// compared every cycle against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned FC   = 3;
  localparam int unsigned TO   = 16;
  localparam int unsigned CW   = 8;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic          mem_req, mem_ready;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_bubble;
  logic [1:0]    state;
  logic          halted, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(
    .FLUSH_CYCLES(FC),
    .MEM_TIMEOUT (TO),
    .CNT_W       (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .ex_rd          (ex_rd),
    .ex_mem_read    (ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .pc_en          (pc_en),
    .if_id_en       (if_id_en),
    .id_ex_en       (id_ex_en),
    .ex_mem_en      (ex_mem_en),
    .if_id_flush    (if_id_flush),
    .id_ex_bubble   (id_ex_bubble),
    .state          (state),
    .halted         (halted),
    .mem_err        (mem_err),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: cycles spent waiting on memory (-1 = not waiting), flush cycles still owed,
  // halt/error flags and the two counters.
  int m_wait  = -1;
  int m_bub   = 0;
  bit m_halt  = 1'b0;
  bit m_err   = 1'b0;
  int m_stall = 0;
  int m_flush = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_bubble}
  function automatic logic [5:0] decode(input bit br, input bit lu);
    if (br) return 6'b111111;
    if (lu) return 6'b001101;
    return 6'b111100;
  endfunction

  // One clock: check DUT against the model mid-cycle, then advance the model.
  task automatic step();
    logic [5:0] exp_ctl;
    int         exp_state;
    bit         lu, ms, was_halt;
    @(negedge clk);
    #1;
    lu = ex_mem_read && (ex_rd != 0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    ms = mem_req && !mem_ready;
    if (reset) begin
      m_wait = -1; m_bub = 0; m_halt = 1'b0; m_err = 1'b0; m_stall = 0; m_flush = 0;
    end
    exp_state = m_halt ? 3 : (m_wait >= 0) ? 1 : (m_bub > 0) ? 2 : 0;
    check("state", state, exp_state);
    check("halted", halted, m_halt);
    check("mem_err", mem_err, m_err);
    check("stall_cnt", stall_cnt, m_stall);
    check("flush_cnt", flush_cnt, m_flush);
    was_halt = m_halt;
    exp_ctl  = 6'b000001;
    if (!reset) begin
      exp_ctl = 6'b000000;
      if (m_halt) begin
        exp_ctl = 6'b000000;
      end else if (m_wait >= 0) begin
        if (mem_ready) begin
          exp_ctl = decode(ex_branch_taken, lu);
          m_wait  = -1;
          if (ex_branch_taken) m_bub = FC - 1;
        end else if (m_wait == TO) begin
          m_halt = 1'b1; m_err = 1'b1; m_wait = -1;
        end else begin
          m_wait++;
        end
      end else if (m_bub > 0) begin
        if (!ms) begin
          exp_ctl = 6'b111111;
          m_bub--;
        end
      end else if (ms) begin
        m_wait = 1;
      end else begin
        exp_ctl = decode(ex_branch_taken, lu);
        if (ex_branch_taken) m_bub = FC - 1;
      end
      if (!exp_ctl[5] && !was_halt && m_stall < CMAX) m_stall++;
      if (exp_ctl[1] && m_flush < CMAX) m_flush++;
    end
    check("ctl", {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_bubble}, exp_ctl);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd1; id_rs2 = 5'd2; ex_rd = 5'd3;
    id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b1;
  endtask

  bit slow = 1'b0;

  initial begin
    idle();
    reset = 1'b1;
    step();
    check("rst_state", state, 0);
    check("rst_bubble", id_ex_bubble, 1);
    check("rst_pc_en", pc_en, 0);
    reset = 1'b0;
    step();

    // Load-use stall for one cycle.
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    step();
    check("t1_stall_cnt", stall_cnt, 1);
    // x0 or unused source: no stall.
    ex_rd = 5'd0; id_rs1 = 5'd0;
    step();
    check("t2_x0_pc_en", pc_en, 1);
    ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b0;
    step();
    check("t2_unused_pc_en", pc_en, 1);
    idle();

    // Taken branch: FC flush cycles.
    ex_branch_taken = 1'b1;
    step();
    check("t3_state_flush", state, 2);
    ex_branch_taken = 1'b0;
    step();
    step();
    check("t3_flush_cnt", flush_cnt, 3);
    check("t3_state_run", state, 0);

    // Memory wait of four cycles.
    mem_req = 1'b1; mem_ready = 1'b0;
    repeat (4) step();
    check("t4_state_wait", state, 1);
    mem_ready = 1'b1;
    step();
    check("t4_state_run", state, 0);

    // Memory timeout to halt.
    mem_ready = 1'b0;
    repeat (17) step();
    check("t5_halted", halted, 1);
    check("t5_mem_err", mem_err, 1);
    repeat (3) step();
    check("t5_still_halted", halted, 1);

    // Reset out of halt and out of flush.
    reset = 1'b1;
    step();
    reset = 1'b0; idle();
    ex_branch_taken = 1'b1;
    step();
    ex_branch_taken = 1'b0; reset = 1'b1;
    step();
    check("t6_state", state, 0);
    check("t6_flush_cnt", flush_cnt, 0);
    reset = 1'b0;

    // Counter saturation.
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
    repeat (300) step();
    check("sat_stall", stall_cnt, CMAX);
    idle();
    ex_branch_taken = 1'b1;
    repeat (300) step();
    check("sat_flush", flush_cnt, CMAX);
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) slow = !slow;
      reset           = ($urandom_range(0, 199) == 0) || (m_halt && $urandom_range(0, 7) == 0);
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      id_uses_rs1     = 1'($urandom);
      id_uses_rs2     = 1'($urandom);
      ex_mem_read     = ($urandom_range(0, 2) == 0);
      ex_branch_taken = ($urandom_range(0, 6) == 0);
      mem_req         = ($urandom_range(0, 3) == 0);
      mem_ready       = slow ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
